fp_div_prep: RTL
================

Name: fp_div_prep

Overview:
- Upstream operand-preparation stage that directly feeds the combinational IEEE-754 single-precision divider.
- Accepts operand pairs over a valid/ready handshake and classifies each operand as zero, denormal, infinity, NaN or normal.
- Resolves every special case locally into a final result, and flags it so the downstream mux bypasses the divider.
- Buffers prepared entries in a small FIFO, so the downstream can stall without stalling the producer.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- QNAN, 32'h7FC0_0000, canonical quiet NaN returned for invalid operations.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operand pair is offered.
- in_ready  output  1  stage can accept this cycle.
- in_a  input  32  dividend, IEEE-754 single.
- in_b  input  32  divisor, IEEE-754 single.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes the head entry.
- out_a  output  32  dividend to divider; denormals flushed to signed zero.
- out_b  output  32  divisor to divider; denormals flushed to signed zero.
- out_bypass  output  1  entry is a special case; the divider output must be ignored.
- out_special  output  32  final result when out_bypass=1, else 0.
- out_invalid  output  1  invalid-operation flag.
- out_div_zero  output  1  divide-by-zero flag.
- occupancy  output  $clog2(DEPTH)+1  entries currently held.

Behaviour:
- Reset:
  - count, wr_ptr and rd_ptr go to 0; out_valid=0; occupancy=0.
  - All out_* data outputs read 0 while the FIFO is empty.
  - in_ready=0 while rst=1.
  - Reset mid-operation discards all buffered entries; there is no partial drain.
- Handshake:
  - Push when in_valid & in_ready; pop when out_valid & out_ready.
  - in_ready = !rst & (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
  - When full, a same-cycle pop does not enable a push: in_ready stays 0 that cycle.
  - When not empty and not full, simultaneous push and pop leave count unchanged and advance both pointers.
  - Pointers wrap modulo DEPTH.
- Latency: a pair accepted in cycle N is visible at the outputs in cycle N+1 if the FIFO was empty. Order is strict FIFO.
- Outputs:
  - out_valid = (count != 0).
  - Data outputs are driven from the head entry and held stable while out_valid & !out_ready.
- Classification (combinational, before the FIFO write), with e = exponent and m = mantissa:
  - zero: e=0. Denormals are treated as zero.
  - inf: e=FF, m=0.
  - nan: e=FF, m!=0.
  - s = a[31]^b[31].
- Special-result priority, first match wins:
  1. Either operand nan -> QNAN, invalid=1.
  2. inf/inf or zero/zero -> QNAN, invalid=1.
  3. Finite nonzero / zero -> {s,8'hFF,23'd0}, div_zero=1.
  4. inf / finite -> {s,8'hFF,23'd0}.
  5. zero / nonzero, or finite / inf -> {s,31'd0}.
  6. Otherwise bypass=0, special=0, flags=0.
- Operand pass-through: out_a and out_b carry the operands with exponent-0 values replaced by {sign,31'd0}. Values are stored regardless of bypass.
- Stored entry width: 32+32+1+32+1+1 = 99 bits.

Decomposition:
- Shared package fp_pkg holds:
  - the fp32 field-width constants (EXP_W=8, MAN_W=23, BIAS=127);
  - the QNAN and POS_INF constants;
  - the operand-class enum {ZERO, NORM, INF, NAN}.
- One sub-module, fp_classify: a combinational per-operand classifier, instantiated twice.
- FIFO storage and pointer logic stay inline.

Test Plan:
- Normal pair: in_a=40C00000 (6.0), in_b=40000000 (2.0), out_ready=1.
  -> Next cycle out_valid=1, bypass=0, out_a=40C00000, out_b=40000000, flags 0, occupancy=1.
- Divide by zero: 3F800000/00000000 -> special=7F800000, div_zero=1. BF800000/80000000 -> special=7F800000 (s=0), div_zero=1.
- Invalid cases:
  - 0/0 (00000000/00000000) -> special=7FC00000, invalid=1.
  - 7FC00001/3F800000 -> 7FC00000, invalid=1.
  - 7F800000/FF800000 -> 7FC00000, invalid=1.
- Infinity, zero and denormal cases:
  - 7F800000/40000000 -> 7F800000.
  - 3F800000/FF800000 -> 80000000.
  - Denormal 00000001/3F800000 -> bypass=1, special=00000000, out_a=00000000.
- Backpressure with out_ready=0:
  - Push P1 and P2 -> in_ready=0 after the second push; P3 is held on in_valid with no loss.
  - Raise out_ready -> outputs P1, P2, P3 in order; in_ready reasserts the cycle after the first pop.
  - Full with simultaneous push and pop attempt -> no push.
- Reset mid-stream: with 2 entries buffered, assert rst for 1 cycle -> out_valid=0, occupancy=0, in_ready=0 during rst and 1 after. A subsequent push appears after 1 cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared fp32 field layout, special constants and operand classes for the
// divider front end.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    // One prepared FIFO entry, 99 bits.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        bypass;
        logic [31:0] special;
        logic        invalid;
        logic        div_zero;
    } prep_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Per-operand classifier: reports the operand class and the operand with
// denormals flushed to a signed zero.
module fp_classify
    import fp_pkg::EXP_W, fp_pkg::MAN_W, fp_pkg::ZERO, fp_pkg::NORM,
           fp_pkg::INF, fp_pkg::NAN;
(
    input  logic [31:0] op,
    output logic [1:0]  cls,
    output logic [31:0] flushed
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f = op[MAN_W +: EXP_W];
    assign man_f = op[MAN_W-1:0];

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cls = NORM;
        if (exp_f == '0) begin
            cls = ZERO;
        end else if (exp_f == '1) begin
            cls = (man_f == '0) ? INF : NAN;
        end
    end

    assign flushed = (exp_f == '0) ? {op[31], 31'd0} : op;

endmodule

// File: rtl/fp_div_prep.sv
// Operand preparation ahead of the combinational fp32 divider: classifies the
// operands, resolves special cases and buffers the result in a small FIFO.
module fp_div_prep
    import fp_pkg::prep_entry_t, fp_pkg::POS_INF, fp_pkg::ZERO,
           fp_pkg::NORM, fp_pkg::INF, fp_pkg::NAN;
#(
    parameter int          DEPTH = 2,
    parameter logic [31:0] QNAN  = fp_pkg::QNAN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_a,
    output logic [31:0]              out_b,
    output logic                     out_bypass,
    output logic [31:0]              out_special,
    output logic                     out_invalid,
    output logic                     out_div_zero,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [1:0]  cls_a, cls_b;
    logic [31:0] flush_a, flush_b;

    fp_classify u_cls_a (.op(in_a), .cls(cls_a), .flushed(flush_a));
    fp_classify u_cls_b (.op(in_b), .cls(cls_b), .flushed(flush_b));

    logic a_zero, a_norm, a_inf, a_nan;
    logic b_zero, b_norm, b_inf, b_nan;
    logic sign;

    assign a_zero = (cls_a == ZERO);
    assign a_norm = (cls_a == NORM);
    assign a_inf  = (cls_a == INF);
    assign a_nan  = (cls_a == NAN);
    assign b_zero = (cls_b == ZERO);
    assign b_norm = (cls_b == NORM);
    assign b_inf  = (cls_b == INF);
    assign b_nan  = (cls_b == NAN);
    assign sign   = in_a[31] ^ in_b[31];

    prep_entry_t wr_entry;

    // Special-result priority: the first matching branch wins.
    always_comb begin
        wr_entry          = '0;
        wr_entry.a        = flush_a;
        wr_entry.b        = flush_b;
        if (a_nan || b_nan) begin
            wr_entry.bypass  = 1'b1;
            wr_entry.special = QNAN;
            wr_entry.invalid = 1'b1;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            wr_entry.bypass  = 1'b1;
            wr_entry.special = QNAN;
            wr_entry.invalid = 1'b1;
        end else if (a_norm && b_zero) begin
            wr_entry.bypass   = 1'b1;
            wr_entry.special  = {sign, POS_INF[30:0]};
            wr_entry.div_zero = 1'b1;
        end else if (a_inf && (b_zero || b_norm)) begin
            wr_entry.bypass  = 1'b1;
            wr_entry.special = {sign, POS_INF[30:0]};
        end else if ((a_zero && (b_norm || b_inf)) || ((a_zero || a_norm) && b_inf)) begin
            wr_entry.bypass  = 1'b1;
            wr_entry.special = {sign, 31'd0};
        end
    end

    prep_entry_t   mem [DEPTH];
    prep_entry_t   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    // Full blocks the producer even when the consumer pops in the same cycle.
    assign in_ready  = !rst && (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; out_valid and the output gating
    // below keep stale contents invisible, and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head         = out_valid ? mem[rd_ptr] : '0;
    assign out_a        = head.a;
    assign out_b        = head.b;
    assign out_bypass   = head.bypass;
    assign out_special  = head.special;
    assign out_invalid  = head.invalid;
    assign out_div_zero = head.div_zero;
    assign occupancy    = count;

endmodule
